// File: rtl/serial_receiver.sv
// Deserializer for the single-wire frame: idle 0, start bit 1, DATA_BITS data bits LSB first, stop bit 0.
// The line shares the receiver clock, so rxd is sampled directly with no synchronizer.
module serial_receiver #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int HALF  = (CLKS_PER_BIT - 1) / 2;
  localparam int CYC_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(CLKS_PER_BIT - 1);
  localparam logic [CYC_W-1:0] HALF_LAST = CYC_W'((HALF > 0) ? HALF - 1 : 0);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t               state, state_next;
  logic [CYC_W-1:0]     cyc_cnt, cyc_next;
  logic [BIT_W-1:0]     bit_cnt, bit_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [DATA_BITS-1:0] data_next;
  logic                 valid_next, err_next;

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_next = state;
    cyc_next   = cyc_cnt;
    bit_next   = bit_cnt;
    shift_next = shift_reg;
    data_next  = data;
    valid_next = 1'b0;
    err_next   = 1'b0;

    case (state)
      WAIT_IDLE: begin
        if (!rxd) state_next = IDLE;
      end

      IDLE: begin
        if (rxd) begin
          cyc_next   = '0;
          bit_next   = '0;
          // At one clock per bit there is no mid-bit re-sample, so the start is confirmed here.
          state_next = (HALF == 0) ? DATA : START;
        end
      end

      START: begin
        if (cyc_cnt == HALF_LAST) begin
          cyc_next   = '0;
          state_next = rxd ? DATA : IDLE;
        end else begin
          cyc_next = cyc_cnt + CYC_W'(1);
        end
      end

      DATA: begin
        if (cyc_cnt == CYC_LAST) begin
          cyc_next = '0;
          for (int i = 0; i < DATA_BITS; i++) begin
            if (bit_cnt == BIT_W'(i)) shift_next[i] = rxd;
          end
          bit_next = bit_cnt + BIT_W'(1);
          if (bit_cnt == BIT_LAST) state_next = STOP;
        end else begin
          cyc_next = cyc_cnt + CYC_W'(1);
        end
      end

      STOP: begin
        if (cyc_cnt == CYC_LAST) begin
          cyc_next = '0;
          if (!rxd) begin
            data_next  = shift_reg;
            valid_next = 1'b1;
            state_next = IDLE;
          end else begin
            // A stuck-high line must drop to 0 before the next start can be trusted.
            err_next   = 1'b1;
            state_next = WAIT_IDLE;
          end
        end else begin
          cyc_next = cyc_cnt + CYC_W'(1);
        end
      end

      default: state_next = WAIT_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WAIT_IDLE;
      cyc_cnt   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_next;
      cyc_cnt   <= cyc_next;
      bit_cnt   <= bit_next;
      shift_reg <= shift_next;
      data      <= data_next;
      valid     <= valid_next;
      frame_err <= err_next;
    end
  end

  assign busy = (state == START) || (state == DATA) || (state == STOP);

endmodule

// File: tb/tb_serial_receiver.sv
// Self-checking bench: one receiver at 1 clk/bit and one at 4 clk/bit, driven by a behavioural line model.
module tb_serial_receiver;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd1, rxd4;
  logic [7:0] data1, data4;
  logic       valid1, valid4, frame_err1, frame_err4, busy1, busy4;

  int checks   = 0;
  int failures = 0;
  int v1_cnt = 0, e1_cnt = 0, v4_cnt = 0, e4_cnt = 0, overlap_cnt = 0;
  logic [7:0] exp1, exp4;

  always #5 clk = ~clk;

  serial_receiver #(.DATA_BITS(8), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .rxd(rxd1), .data(data1),
    .valid(valid1), .frame_err(frame_err1), .busy(busy1)
  );

  serial_receiver #(.DATA_BITS(8), .CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .rxd(rxd4), .data(data4),
    .valid(valid4), .frame_err(frame_err4), .busy(busy4)
  );

  // Pulse counters and illegal-combination tally, sampled mid-cycle.
  always @(negedge clk) begin
    if (valid1 === 1'b1) v1_cnt++;
    if (frame_err1 === 1'b1) e1_cnt++;
    if (valid4 === 1'b1) v4_cnt++;
    if (frame_err4 === 1'b1) e4_cnt++;
    if ((valid1 === 1'b1 && frame_err1 === 1'b1) || (valid4 === 1'b1 && frame_err4 === 1'b1)) overlap_cnt++;
    if (rst === 1'b1 && (valid1 === 1'b1 || frame_err1 === 1'b1 || valid4 === 1'b1 || frame_err4 === 1'b1))
      overlap_cnt++;
  end

  // Hold the line of the selected receiver at v for n clocks; returns 1 time unit after the last edge.
  task automatic drive(input int c, input logic v, input int n);
    for (int k = 0; k < n; k++) begin
      if (c == 1) rxd1 = v; else rxd4 = v;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int c, input logic [7:0] b, input logic stop_bit);
    drive(c, 1'b1, c);
    for (int i = 0; i < 8; i++) drive(c, b[i], c);
    drive(c, stop_bit, c);
  endtask

  task automatic test_reset;
    rst = 1'b1; rxd1 = 1'b0; rxd4 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (data1 !== 8'h00) begin failures++; $display("FAIL reset_data1: got %h expected 00", data1); end
    checks++; if ({valid1, frame_err1, busy1} !== 3'b000) begin failures++; $display("FAIL reset_flags1: got %b expected 000", {valid1, frame_err1, busy1}); end
    checks++; if ({valid4, frame_err4, busy4, data4} !== 11'd0) begin failures++; $display("FAIL reset_dut4: got %h expected 0", {valid4, frame_err4, busy4, data4}); end
    rst = 1'b0;
    exp1 = 8'h00; exp4 = 8'h00;
  endtask

  task automatic test_basic;
    drive(1, 1'b0, 2);
    send(1, 8'hA5, 1'b0);
    exp1 = 8'hA5;
    checks++; if (valid1 !== 1'b1) begin failures++; $display("FAIL basic_valid: got %b expected 1", valid1); end
    checks++; if (data1 !== exp1) begin failures++; $display("FAIL basic_data: got %h expected %h", data1, exp1); end
    checks++; if (frame_err1 !== 1'b0) begin failures++; $display("FAIL basic_err: got %b expected 0", frame_err1); end
    drive(1, 1'b0, 1);
    checks++; if (valid1 !== 1'b0) begin failures++; $display("FAIL basic_pulse_width: got %b expected 0", valid1); end
  endtask

  task automatic test_back_to_back;
    int v0;
    v0 = v1_cnt;
    send(1, 8'h3C, 1'b0);
    checks++; if ({valid1, data1} !== {1'b1, 8'h3C}) begin failures++; $display("FAIL b2b_first: got %b/%h expected 1/3c", valid1, data1); end
    send(1, 8'hC3, 1'b0);
    exp1 = 8'hC3;
    checks++; if ({valid1, data1} !== {1'b1, exp1}) begin failures++; $display("FAIL b2b_second: got %b/%h expected 1/%h", valid1, data1, exp1); end
    drive(1, 1'b0, 2);
    checks++; if (v1_cnt - v0 !== 2) begin failures++; $display("FAIL b2b_count: got %0d expected 2", v1_cnt - v0); end
  endtask

  task automatic test_frame_err;
    int v0;
    send(1, 8'h5A, 1'b1);
    checks++; if ({frame_err1, valid1} !== 2'b10) begin failures++; $display("FAIL err_pulse: got %b expected 10", {frame_err1, valid1}); end
    checks++; if (data1 !== exp1) begin failures++; $display("FAIL err_data_held: got %h expected %h", data1, exp1); end
    v0 = v1_cnt;
    for (int k = 0; k < 3; k++) begin
      drive(1, 1'b1, 1);
      checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL err_no_rearm: got %b expected 0", busy1); end
    end
    drive(1, 1'b0, 1);
    send(1, 8'h11, 1'b0);
    exp1 = 8'h11;
    checks++; if ({valid1, data1} !== {1'b1, exp1}) begin failures++; $display("FAIL err_recover: got %b/%h expected 1/%h", valid1, data1, exp1); end
    drive(1, 1'b0, 1);
    checks++; if (v1_cnt - v0 !== 1) begin failures++; $display("FAIL err_valid_count: got %0d expected 1", v1_cnt - v0); end
  endtask

  task automatic test_glitch_c4;
    int v0, e0;
    v0 = v4_cnt; e0 = e4_cnt;
    drive(4, 1'b1, 1);
    checks++; if (busy4 !== 1'b1) begin failures++; $display("FAIL glitch_detect: got %b expected 1", busy4); end
    drive(4, 1'b0, 1);
    checks++; if (busy4 !== 1'b0) begin failures++; $display("FAIL glitch_reject: got %b expected 0", busy4); end
    drive(4, 1'b0, 3);
    send(4, 8'h81, 1'b0);
    drive(4, 1'b0, 4);
    exp4 = 8'h81;
    checks++; if (v4_cnt - v0 !== 1) begin failures++; $display("FAIL c4_valid_count: got %0d expected 1", v4_cnt - v0); end
    checks++; if (e4_cnt !== e0) begin failures++; $display("FAIL c4_err_count: got %0d expected %0d", e4_cnt, e0); end
    checks++; if (data4 !== exp4) begin failures++; $display("FAIL c4_data: got %h expected %h", data4, exp4); end
  endtask

  task automatic test_reset_mid;
    int v0, e0;
    v0 = v1_cnt; e0 = e1_cnt;
    drive(1, 1'b1, 5);
    rst = 1'b1;
    drive(1, 1'b1, 2);
    exp1 = 8'h00; exp4 = 8'h00;
    checks++; if ({data1, valid1, busy1} !== 10'd0) begin failures++; $display("FAIL midrst_state: got %h expected 0", {data1, valid1, busy1}); end
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      drive(1, 1'b1, 1);
      if (busy1 !== 1'b0) begin checks++; failures++; $display("FAIL midrst_armed_early: cycle %0d got %b expected 0", k, busy1); end
    end
    checks++; if ({v1_cnt, e1_cnt} !== {v0, e0}) begin failures++; $display("FAIL midrst_pulses: got %0d/%0d expected %0d/%0d", v1_cnt, e1_cnt, v0, e0); end
    drive(1, 1'b0, 1);
    send(1, 8'h3E, 1'b0);
    exp1 = 8'h3E;
    checks++; if ({valid1, data1} !== {1'b1, exp1}) begin failures++; $display("FAIL midrst_recover: got %b/%h expected 1/%h", valid1, data1, exp1); end
  endtask

  task automatic test_loopback;
    logic [7:0] tx [3];
    int e0;
    tx[0] = 8'h00; tx[1] = 8'h55; tx[2] = 8'hFF;
    e0 = e1_cnt;
    for (int i = 0; i < 3; i++) begin
      send(1, tx[i], 1'b0);
      exp1 = tx[i];
      checks++; if ({valid1, data1} !== {1'b1, exp1}) begin failures++; $display("FAIL loopback_%0d: got %b/%h expected 1/%h", i, valid1, data1, exp1); end
    end
    drive(1, 1'b0, 1);
    checks++; if (e1_cnt !== e0) begin failures++; $display("FAIL loopback_err: got %0d expected %0d", e1_cnt, e0); end
  endtask

  // Random frames on either receiver; the model keeps the last good byte per receiver.
  task automatic test_random;
    int c, v0, e0;
    logic [7:0] b;
    logic bad;
    for (int n = 0; n < 24; n++) begin
      c   = ($urandom_range(0, 3) == 0) ? 4 : 1;
      b   = 8'($urandom);
      bad = ($urandom_range(0, 4) == 0);
      v0  = (c == 1) ? v1_cnt : v4_cnt;
      e0  = (c == 1) ? e1_cnt : e4_cnt;
      send(c, b, bad);
      if (c == 1) begin
        if (!bad) exp1 = b;
        checks++; if ({valid1, frame_err1, data1} !== {!bad, bad, exp1}) begin failures++; $display("FAIL rand_c1_%0d: got %b%b/%h expected %b%b/%h", n, valid1, frame_err1, data1, !bad, bad, exp1); end
      end else begin
        if (!bad) exp4 = b;
        checks++; if ({v4_cnt - v0, e4_cnt - e0} !== {32'(!bad), 32'(bad)}) begin failures++; $display("FAIL rand_c4_pulses_%0d: got %0d/%0d expected %0d/%0d", n, v4_cnt - v0, e4_cnt - e0, !bad, bad); end
        checks++; if (data4 !== exp4) begin failures++; $display("FAIL rand_c4_data_%0d: got %h expected %h", n, data4, exp4); end
      end
      drive(c, 1'b0, bad ? $urandom_range(1, 3) : $urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_frame_err();
    test_glitch_c4();
    test_reset_mid();
    test_loopback();
    test_random();
    drive(1, 1'b0, 2);
    checks++; if (overlap_cnt !== 0) begin failures++; $display("FAIL exclusive_pulses: got %0d expected 0", overlap_cnt); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
